uart_tx_arbiter: RTL

- Shares the single UART transmit FIFO write port between NUM_REQ byte-stream requesters (e.g. CPU APB path, debug monitor, DMA).
- Round-robin arbitration with message locking: a granted requester keeps the FIFO until it marks the last byte, hits the burst cap, or stalls past a timeout.
- Sits between the requesters and the UART transmit FIFO inputs (tx_fifo_dataIn, tx_fifo_writeEn, tx_fifo_Full).

---
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX FIFO write port between NUM_REQ byte streams: round-robin with message lock.
// Define UART_ARB_PRIORITY_EN to give requester 0 fixed priority and exempt it from MAX_BURST.
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned IDLE_TIMEOUT = 255,
    localparam int unsigned IdW         = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    input  logic [NUM_REQ-1:0]               req_last,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             tx_fifo_Full,
    output logic [DATA_WIDTH-1:0]            tx_fifo_dataIn,
    output logic                             tx_fifo_writeEn,
    output logic [IdW-1:0]                   grant_id,
    output logic                             busy
);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e         state_q, state_d;
    // The granted id doubles as last_grant: both are loaded together on arbitration.
    logic [IdW-1:0] grant_q, grant_d;
    logic [7:0]     burst_q, burst_d;
    logic [7:0]     idle_q, idle_d;
    logic           busy_q, busy_d;

    logic [IdW-1:0] arb_sel;
    logic [IdW-1:0] arb_cand;
    logic           arb_found;

    logic           xfer;
    logic           cap_hit;
    logic [7:0]     burst_inc;
    logic [7:0]     idle_inc;

    // Round-robin search starting one past the previous grant.
    always_comb begin
        arb_sel   = grant_q;
        arb_cand  = '0;
        arb_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            arb_cand = IdW'((32'(grant_q) + k) % NUM_REQ);
            if (!arb_found && req_valid[arb_cand]) begin
                arb_sel   = arb_cand;
                arb_found = 1'b1;
            end
        end
`ifdef UART_ARB_PRIORITY_EN
        if (req_valid[0]) begin
            arb_sel = '0;
        end
`endif
    end

    always_comb begin
        xfer      = (state_q == StLock) && req_valid[grant_q] && !tx_fifo_Full;
        burst_inc = burst_q + 8'd1;
        idle_inc  = idle_q + 8'd1;
`ifdef UART_ARB_PRIORITY_EN
        cap_hit   = (burst_inc == 8'(MAX_BURST)) && (grant_q != '0);
`else
        cap_hit   = (burst_inc == 8'(MAX_BURST));
`endif
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        burst_d = burst_q;
        idle_d  = idle_q;
        case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    grant_d = arb_sel;
                    burst_d = '0;
                    idle_d  = '0;
                    state_d = StLock;
                end
            end
            StLock: begin
                if (xfer) begin
                    burst_d = burst_inc;
                    idle_d  = '0;
                    if (req_last[grant_q] || cap_hit) begin
                        state_d = StIdle;
                    end
                end else if (!req_valid[grant_q]) begin
                    idle_d = idle_inc;
                    if (idle_inc == 8'(IDLE_TIMEOUT)) begin
                        state_d = StIdle;
                    end
                end
                // A full FIFO with valid high holds everything: the grant is kept.
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StLock);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= IdW'(NUM_REQ - 1);
            burst_q <= '0;
            idle_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
            idle_q  <= idle_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        req_ready       = '0;
        tx_fifo_writeEn = 1'b0;
        tx_fifo_dataIn  = '0;
        if (state_q == StLock) begin
            req_ready[grant_q] = !tx_fifo_Full;
            tx_fifo_writeEn    = xfer;
            tx_fifo_dataIn     = req_data[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule
